// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the stage-2 branch resolver: FSM encoding, address width
// and the bit ranges the prediction table uses to split a PC+4 into index and tag.
package branch_resolver_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

    localparam int ADDR_W_DEF = 32;

    localparam int IDX_MSB = 5;
    localparam int IDX_LSB = 2;
    localparam int TAG_MSB = 31;
    localparam int TAG_LSB = 6;

endpackage

// File: rtl/branch_stats.sv
// Resolved-branch and mispredict counters; only built when BRANCH_STATS_EN is defined.
module branch_stats (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        br_i,
    input  logic        miss_i,
    output logic [31:0] br_count_o,
    output logic [31:0] miss_count_o
);

    logic [31:0] br_q, br_d;
    logic [31:0] miss_q, miss_d;

    always_comb begin
        br_d   = br_q;
        miss_d = miss_q;
        if (br_i)   br_d   = br_q + 32'd1;
        if (miss_i) miss_d = miss_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_q   <= '0;
            miss_q <= '0;
        end else begin
            br_q   <= br_d;
            miss_q <= miss_d;
        end
    end

    assign br_count_o   = br_q;
    assign miss_count_o = miss_q;

endmodule

// File: rtl/branch_resolver.sv
// Stage-2 BEQ resolver: carries the fetch prediction through IF/ID, drives table updates
// and redirect/flush on a mispredict. Statistics counters exist only with BRANCH_STATS_EN.
//
//   state     | meaning
//   ST_NORMAL | stage 2 resolves whatever IF/ID holds
//   ST_SQUASH | bubble cycle after a redirect; nothing resolves
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc4,
    input  logic              H,
    input  logic              P,
    input  logic [ADDR_W-1:0] Target,
    input  logic              fetch_valid,
    input  logic              stall,
    input  logic              br_s2,
    input  logic              eq_s2,
    input  logic [ADDR_W-1:0] baddr_in_s2,
    output logic              WRt,
    output logic              WRp,
    output logic              C,
    output logic [ADDR_W-1:0] pc4_s2,
    output logic [ADDR_W-1:0] baddr_s2,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic [31:0]       br_count,
    output logic [31:0]       miss_count
);

    state_e            state_q, state_d;
    logic              v2_q, v2_d, h2_q, h2_d, p2_q, p2_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d, t2_q, t2_d;
    logic              active, mispredict;
    logic [ADDR_W-1:0] rpc;

    always_comb begin
        active     = v2_q & ~stall & (state_q == ST_NORMAL);
        WRt        = 1'b0;
        WRp        = 1'b0;
        C          = 1'b0;
        mispredict = 1'b0;
        rpc        = '0;
        if (active & br_s2) begin
            WRt = ~h2_q;
            WRp = 1'b1;
            C   = eq_s2;
            if (!h2_q) begin
                mispredict = eq_s2;
                rpc        = baddr_in_s2;
            end else begin
                // wrong direction, or taken as predicted but to a stale target
                mispredict = (p2_q != eq_s2) | (p2_q & eq_s2 & (t2_q != baddr_in_s2));
                rpc        = eq_s2 ? baddr_in_s2 : pc4_q;
            end
        end else if (active & h2_q & p2_q) begin
            mispredict = 1'b1;
            rpc        = pc4_q;
        end
    end

    assign redirect    = mispredict;
    assign flush       = mispredict;
    assign redirect_pc = mispredict ? rpc : '0;
    assign pc4_s2      = pc4_q;
    assign baddr_s2    = baddr_in_s2;

    always_comb begin
        v2_d  = v2_q;
        pc4_d = pc4_q;
        h2_d  = h2_q;
        p2_d  = p2_q;
        t2_d  = t2_q;
        if (!stall) begin
            v2_d  = fetch_valid & ~mispredict;
            pc4_d = pc4;
            h2_d  = H;
            p2_d  = P;
            t2_d  = Target;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL: if (mispredict) state_d = ST_SQUASH;
            ST_SQUASH: if (!stall)     state_d = ST_NORMAL;
            default:                   state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            v2_q    <= 1'b0;
            pc4_q   <= '0;
            h2_q    <= 1'b0;
            p2_q    <= 1'b0;
            t2_q    <= '0;
        end else begin
            state_q <= state_d;
            v2_q    <= v2_d;
            pc4_q   <= pc4_d;
            h2_q    <= h2_d;
            p2_q    <= p2_d;
            t2_q    <= t2_d;
        end
    end

`ifdef BRANCH_STATS_EN
    branch_stats u_stats (
        .clk_i        (clk),
        .rst_i        (rst),
        .br_i         (active & br_s2),
        .miss_i       (mispredict),
        .br_count_o   (br_count),
        .miss_count_o (miss_count)
    );
`else
    assign br_count   = '0;
    assign miss_count = '0;
`endif

endmodule
